id_ex_pipe_ctrl: RTL and testbench

Sequencer for the ID/EX pipeline register that feeds the EX stage. It loads decoded operands and control from ID and holds them while EX raises a load-use stall. On a branch flush from MEM it squashes the register into NOPE bubbles for a fixed number of cycles. It also drives the upstream hold to IF/ID and flags stalls that exceed a bound.

---
 rtl/id_ex_pipe_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_id_ex_pipe_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_ctrl.sv
// ID/EX pipeline register sequencer: load/hold/bubble control, upstream hold, stall watchdog; optional perf counters under ID_EX_PERF_CNT_EN.
// Latency: ID fields appear on ID_EX outputs 1 cycle after the sampling edge; IF_ID_hold is combinational.
// Backpressure: EX_stall freezes the register and raises IF_ID_hold; MEM_flush squashes to bubbles for FLUSH_DEPTH cycles.
module id_ex_pipe_ctrl #(
    parameter logic [3:0] ALU_OP_NOPE = 4'd9,
    parameter int         FLUSH_DEPTH = 2,
    parameter int         STALL_MAX   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_valid,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic [4:0]  ID_rd,
    input  logic [31:0] ID_rs1_data,
    input  logic [31:0] ID_rs2_data,
    input  logic [31:0] ID_imme,
    input  logic [3:0]  ID_aluop,
    input  logic [6:0]  ID_ctrl,
    input  logic        EX_stall,
    input  logic        MEM_flush,
    output logic [4:0]  ID_EX_rs1,
    output logic [4:0]  ID_EX_rs2,
    output logic [4:0]  ID_EX_rd,
    output logic [31:0] ID_EX_rs1_data,
    output logic [31:0] ID_EX_rs2_data,
    output logic [31:0] ID_EX_imme,
    output logic [3:0]  ID_EX_aluop,
    output logic        ID_EX_branch,
    output logic        ID_EX_alusrc,
    output logic        ID_EX_memread,
    output logic        ID_EX_memtoreg,
    output logic        ID_EX_memwrite,
    output logic        ID_EX_regwrite,
    output logic        ID_EX_take,
    output logic        ID_EX_valid,
    output logic        IF_ID_hold,
    output logic        stall_err,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
);

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imme;
        logic [3:0]  aluop;
        logic [6:0]  ctrl;
        logic        valid;
    } idex_t;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
    localparam logic [3:0] STALL_LIMIT  = 4'(STALL_MAX);
    // A single-cycle flush never needs the FLUSH state.
    localparam state_t     FLUSH_NEXT   = (FLUSH_DEPTH > 1) ? FLUSH : RUN;

    state_t     state_q, state_d;
    idex_t      pipe_q, pipe_d;
    idex_t      bubble, id_load;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [3:0] stall_cnt_q, stall_cnt_d;
    logic       stall_err_q, stall_err_d;

    always_comb begin
        bubble       = '0;
        bubble.aluop = ALU_OP_NOPE;
    end

    always_comb begin
        id_load          = '0;
        id_load.rs1      = ID_rs1;
        id_load.rs2      = ID_rs2;
        id_load.rd       = ID_rd;
        id_load.rs1_data = ID_rs1_data;
        id_load.rs2_data = ID_rs2_data;
        id_load.imme     = ID_imme;
        id_load.aluop    = ID_aluop;
        id_load.ctrl     = ID_ctrl;
        id_load.valid    = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        pipe_d      = pipe_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err_q;
        case (state_q)
            RUN, STALL: begin
                // Flush wins over stall: the stalled instruction is squashed anyway.
                if (MEM_flush) begin
                    pipe_d      = bubble;
                    flush_cnt_d = FLUSH_RELOAD;
                    stall_cnt_d = 4'd0;
                    state_d     = FLUSH_NEXT;
                end else if (EX_stall) begin
                    if (state_q == RUN) begin
                        stall_cnt_d = 4'd1;
                    end else if (stall_cnt_q != 4'd15) begin
                        stall_cnt_d = stall_cnt_q + 4'd1;
                    end
                    if (stall_cnt_d >= STALL_LIMIT) begin
                        stall_err_d = 1'b1;
                    end
                    state_d = STALL;
                end else begin
                    pipe_d      = ID_valid ? id_load : bubble;
                    stall_cnt_d = 4'd0;
                    state_d     = RUN;
                end
            end
            FLUSH: begin
                pipe_d = bubble;
                if (MEM_flush) begin
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    state_d     = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                pipe_d  = bubble;
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pipe_q      <= bubble;
            flush_cnt_q <= 3'd0;
            stall_cnt_q <= 4'd0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pipe_q      <= pipe_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign IF_ID_hold = (EX_stall & ~MEM_flush & (state_q != FLUSH)) | (state_q == FLUSH);

    assign ID_EX_rs1      = pipe_q.rs1;
    assign ID_EX_rs2      = pipe_q.rs2;
    assign ID_EX_rd       = pipe_q.rd;
    assign ID_EX_rs1_data = pipe_q.rs1_data;
    assign ID_EX_rs2_data = pipe_q.rs2_data;
    assign ID_EX_imme     = pipe_q.imme;
    assign ID_EX_aluop    = pipe_q.aluop;
    assign ID_EX_valid    = pipe_q.valid;
    assign {ID_EX_branch, ID_EX_alusrc, ID_EX_memread, ID_EX_memtoreg,
            ID_EX_memwrite, ID_EX_regwrite, ID_EX_take} = pipe_q.ctrl;
    assign stall_err      = stall_err_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] perf_stall_q, perf_flush_q;
    logic        hold_cyc, flush_cyc;

    assign hold_cyc  = (state_q != FLUSH) & EX_stall & ~MEM_flush;
    assign flush_cyc = (state_q == FLUSH) | MEM_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 16'd0;
            perf_flush_q <= 16'd0;
        end else begin
            if (hold_cyc) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
            if (flush_cyc) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = 16'd0;
    assign perf_flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// Randomized scoreboard bench for id_ex_pipe_ctrl against a behavioural pipeline-register model.
module tb_id_ex_pipe_ctrl;

    localparam logic [3:0] NOPE = 4'd9;
    localparam int         FD   = 2;
    localparam int         SM   = 3;
`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  aluop;
        logic [6:0]  ctrl;
        logic        valid;
        logic        err;
        logic [15:0] ps;
        logic [15:0] pf;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } reg_exp_t;

    typedef struct {
        int   cyc;
        logic hold;
    } hold_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ID_valid = 1'b0;
    logic [4:0]  ID_rs1 = '0, ID_rs2 = '0, ID_rd = '0;
    logic [31:0] ID_rs1_data = '0, ID_rs2_data = '0, ID_imme = '0;
    logic [3:0]  ID_aluop = '0;
    logic [6:0]  ID_ctrl = '0;
    logic        EX_stall = 1'b0, MEM_flush = 1'b0;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [31:0] ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imme;
    logic [3:0]  ID_EX_aluop;
    logic        ID_EX_branch, ID_EX_alusrc, ID_EX_memread, ID_EX_memtoreg;
    logic        ID_EX_memwrite, ID_EX_regwrite, ID_EX_take, ID_EX_valid;
    logic        IF_ID_hold, stall_err;
    logic [15:0] perf_stall_cnt, perf_flush_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit fix_fields = 1'b0;

    reg_exp_t  reg_q[$];
    hold_exp_t hold_q[$];

    // Behavioural model: register contents plus remaining flush bubbles and stall-run length.
    obs_t        m_regs;
    int          m_flush_left = 0;
    int          m_run = 0;
    logic        m_err = 1'b0;
    logic [15:0] m_ps = '0, m_pf = '0;

    id_ex_pipe_ctrl #(.ALU_OP_NOPE(NOPE), .FLUSH_DEPTH(FD), .STALL_MAX(SM)) dut (
        .clk(clk), .rst(rst), .ID_valid(ID_valid),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imme(ID_imme),
        .ID_aluop(ID_aluop), .ID_ctrl(ID_ctrl),
        .EX_stall(EX_stall), .MEM_flush(MEM_flush),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imme(ID_EX_imme),
        .ID_EX_aluop(ID_EX_aluop),
        .ID_EX_branch(ID_EX_branch), .ID_EX_alusrc(ID_EX_alusrc), .ID_EX_memread(ID_EX_memread),
        .ID_EX_memtoreg(ID_EX_memtoreg), .ID_EX_memwrite(ID_EX_memwrite),
        .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_take(ID_EX_take),
        .ID_EX_valid(ID_EX_valid), .IF_ID_hold(IF_ID_hold), .stall_err(stall_err),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t bubble_obs();
        obs_t b;
        b       = '0;
        b.aluop = NOPE;
        return b;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.rs1   = ID_EX_rs1;       o.rs2 = ID_EX_rs2;       o.rd  = ID_EX_rd;
        o.d1    = ID_EX_rs1_data;  o.d2  = ID_EX_rs2_data;  o.imm = ID_EX_imme;
        o.aluop = ID_EX_aluop;
        o.ctrl  = {ID_EX_branch, ID_EX_alusrc, ID_EX_memread, ID_EX_memtoreg,
                   ID_EX_memwrite, ID_EX_regwrite, ID_EX_take};
        o.valid = ID_EX_valid;
        o.err   = stall_err;
        o.ps    = perf_stall_cnt;
        o.pf    = perf_flush_cnt;
        return o;
    endfunction

    // Applies one cycle of stimulus, queues the expectations, and advances to just past the edge.
    task automatic step(input logic r, input logic v, input logic s, input logic f);
        hold_exp_t he;
        reg_exp_t  re;
        rst = r; ID_valid = v; EX_stall = s; MEM_flush = f;
        if (!fix_fields) begin
            ID_rs1      = 5'($urandom);
            ID_rs2      = 5'($urandom);
            ID_rd       = 5'($urandom);
            ID_rs1_data = $urandom;
            ID_rs2_data = $urandom;
            ID_imme     = $urandom;
            ID_aluop    = 4'($urandom);
            ID_ctrl     = 7'($urandom);
        end
        he.cyc  = cyc;
        he.hold = (m_flush_left > 0) || (s && !f);
        hold_q.push_back(he);

        if (r) begin
            m_regs = bubble_obs(); m_flush_left = 0; m_run = 0; m_err = 1'b0; m_ps = '0; m_pf = '0;
        end else if (m_flush_left > 0) begin
            m_regs       = bubble_obs();
            m_flush_left = f ? FD - 1 : m_flush_left - 1;
            m_pf         = m_pf + 16'd1;
        end else if (f) begin
            m_regs       = bubble_obs();
            m_flush_left = FD - 1;
            m_run        = 0;
            m_pf         = m_pf + 16'd1;
        end else if (s) begin
            m_run = m_run + 1;
            if (m_run >= SM) m_err = 1'b1;
            m_ps = m_ps + 16'd1;
        end else begin
            m_run = 0;
            if (v) begin
                m_regs       = '0;
                m_regs.rs1   = ID_rs1;      m_regs.rs2 = ID_rs2;      m_regs.rd  = ID_rd;
                m_regs.d1    = ID_rs1_data; m_regs.d2  = ID_rs2_data; m_regs.imm = ID_imme;
                m_regs.aluop = ID_aluop;
                m_regs.ctrl  = ID_ctrl;
                m_regs.valid = 1'b1;
            end else begin
                m_regs = bubble_obs();
            end
        end
        re.cyc  = cyc + 1;
        re.o    = m_regs;
        re.o.err = m_err;
        re.o.ps = PERF_ON ? m_ps : 16'd0;
        re.o.pf = PERF_ON ? m_pf : 16'd0;
        reg_q.push_back(re);

        @(posedge clk);
        #2;
    endtask

    // Monitor: compares queued expectations whose cycle tag matches the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (hold_q.size() > 0 && hold_q[0].cyc <= cyc) begin
                hold_exp_t he;
                he = hold_q.pop_front();
                tests++;
                if (he.cyc != cyc || IF_ID_hold !== he.hold) begin
                    fails++;
                    $display("FAIL hold cyc=%0d tag=%0d got=%b exp=%b", cyc, he.cyc, IF_ID_hold, he.hold);
                end
            end
            while (reg_q.size() > 0 && reg_q[0].cyc <= cyc) begin
                reg_exp_t re;
                obs_t     act;
                re  = reg_q.pop_front();
                act = dut_obs();
                tests++;
                if (re.cyc != cyc || act !== re.o) begin
                    fails++;
                    $display("FAIL regs cyc=%0d tag=%0d got=%h exp=%h", cyc, re.cyc, act, re.o);
                end
            end
        end
    end

    initial begin
        int burst;
        m_regs = bubble_obs();
        @(posedge clk);
        #2;
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);

        // Directed: single load with known fields.
        fix_fields  = 1'b1;
        ID_rs1 = 5'd1; ID_rs2 = 5'd2; ID_rd = 5'd3;
        ID_rs1_data = 32'd5; ID_rs2_data = 32'd6; ID_imme = 32'd7;
        ID_aluop = 4'd0; ID_ctrl = 7'b0000010;
        step(0, 1, 0, 0);
        fix_fields  = 1'b0;
        // One-cycle stall, then next load.
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        // Flush with FLUSH_DEPTH bubbles, then a real load.
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        // Simultaneous stall and flush.
        step(0, 1, 1, 1);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        // Long stall trips the watchdog; it must stay set.
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        // Reset mid-flush, then normal loads.
        step(0, 1, 0, 1);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        // Reset mid-stall.
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);

        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r, v, s, f;
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(2, 6);
            r = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 9) < 7);
            s = (burst > 0) || ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 11) == 0);
            if (burst > 0) burst--;
            step(r, v, s, f);
        end

        step(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (reg_q.size() != 0 || hold_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d/%0d exp=0/0", reg_q.size(), hold_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
